// File: rtl/bless_alloc_pkg.sv
// Shared defaults, port index constants and helpers for the BLESS port allocator.
package bless_alloc_pkg;

    localparam int NUM_PORT_DEF = 4;
    localparam int NUM_FLIT_DEF = 4;
    localparam int CNT_W_DEF    = 16;
    localparam int POP_W        = 32;

    // Output port bit positions within a port mask
    localparam int PORT_N = 3;
    localparam int PORT_E = 2;
    localparam int PORT_S = 1;
    localparam int PORT_W = 0;

    // Number of set bits in a (zero-extended) vector
    function automatic logic [POP_W-1:0] popcount(input logic [POP_W-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + {{(POP_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bless_alloc_slice.sv
// Single-flit allocation step plus the MSB-first one-hot picker it uses.
import bless_alloc_pkg::*;

module bless_alloc_pick #(
    parameter int W = 4
) (
    input  logic [W-1:0] vec,
    output logic [W-1:0] onehot
);

    // Highest set bit wins: later (higher) indices overwrite earlier ones
    always_comb begin
        onehot = '0;
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

module bless_alloc_slice #(
    parameter int NUM_PORT = NUM_PORT_DEF
) (
    input  logic                valid,
    input  logic [NUM_PORT-1:0] prod,
    input  logic [NUM_PORT-1:0] free_in,
    output logic [NUM_PORT-1:0] grant,
    output logic                defl,
    output logic                ovf,
    output logic [NUM_PORT-1:0] free_out
);

    logic [NUM_PORT-1:0] req;
    logic [NUM_PORT-1:0] req_oh;
    logic [NUM_PORT-1:0] free_oh;

    assign req = prod & free_in;

    bless_alloc_pick #(.W(NUM_PORT)) u_pick_req  (.vec(req),     .onehot(req_oh));
    bless_alloc_pick #(.W(NUM_PORT)) u_pick_free (.vec(free_in), .onehot(free_oh));

    // Productive port first, otherwise deflect to any free port; invalid flits take nothing
    always_comb begin
        grant = '0;
        defl  = 1'b0;
        ovf   = 1'b0;
        if (valid) begin
            if (|req) begin
                grant = req_oh;
            end else if (|free_in) begin
                grant = free_oh;
                defl  = 1'b1;
            end else begin
                ovf = 1'b1;
            end
        end
    end

    assign free_out = free_in & ~grant;

endmodule

// File: rtl/bless_port_alloc.sv
// BLESS output-port allocator: chained per-flit slices, registered grants and
// saturating deflection counter. Define BLESS_ALLOC_STATS_EN to add per-port
// grant counters on output grant_cnt.
import bless_alloc_pkg::*;

module bless_port_alloc #(
    parameter int NUM_PORT = NUM_PORT_DEF,
    parameter int NUM_FLIT = NUM_FLIT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_FLIT-1:0]          in_valid,
    input  logic [NUM_FLIT*NUM_PORT-1:0] in_prod,
    input  logic [NUM_PORT-1:0]          port_en,
    input  logic                         cnt_clr,
    output logic [NUM_FLIT-1:0]          out_valid,
    output logic [NUM_FLIT*NUM_PORT-1:0] out_grant,
    output logic [NUM_FLIT-1:0]          out_defl,
    output logic                         out_ovf,
    output logic [CNT_W-1:0]             defl_cnt
`ifdef BLESS_ALLOC_STATS_EN
   ,output logic [NUM_PORT*CNT_W-1:0]    grant_cnt
`endif
);

    logic [NUM_FLIT:0][NUM_PORT-1:0]   free_chain;
    logic [NUM_FLIT-1:0][NUM_PORT-1:0] grant_nxt;
    logic [NUM_FLIT-1:0]               defl_nxt;
    logic [NUM_FLIT-1:0]               ovf_nxt;

    assign free_chain[0] = port_en;

    // Flit 0 allocates first; each slice passes the remaining free mask on
    for (genvar f = 0; f < NUM_FLIT; f++) begin : g_slice
        bless_alloc_slice #(.NUM_PORT(NUM_PORT)) u_slice (
            .valid    (in_valid[f]),
            .prod     (in_prod[f*NUM_PORT +: NUM_PORT]),
            .free_in  (free_chain[f]),
            .grant    (grant_nxt[f]),
            .defl     (defl_nxt[f]),
            .ovf      (ovf_nxt[f]),
            .free_out (free_chain[f+1])
        );
    end

    logic [POP_W-1:0] pop;
    logic [CNT_W:0]   defl_sum;
    logic [CNT_W-1:0] defl_cnt_nxt;

    // Saturating add of this cycle's deflections; one spare bit catches the carry
    always_comb begin
        pop          = popcount({{(POP_W-NUM_FLIT){1'b0}}, defl_nxt});
        defl_sum     = {1'b0, defl_cnt} + pop[CNT_W:0];
        defl_cnt_nxt = defl_sum[CNT_W] ? {CNT_W{1'b1}} : defl_sum[CNT_W-1:0];
    end

    // Result registers and deflection counter, clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_grant <= '0;
            out_defl  <= '0;
            out_ovf   <= 1'b0;
            defl_cnt  <= '0;
        end else begin
            out_valid <= in_valid;
            out_grant <= grant_nxt;
            out_defl  <= defl_nxt;
            out_ovf   <= |ovf_nxt;
            defl_cnt  <= cnt_clr ? '0 : defl_cnt_nxt;
        end
    end

`ifdef BLESS_ALLOC_STATS_EN
    // Grants are disjoint, so each port sees at most one grant per cycle
    for (genvar p = 0; p < NUM_PORT; p++) begin : g_stat
        logic port_hit;
        always_comb begin
            port_hit = 1'b0;
            for (int f = 0; f < NUM_FLIT; f++) begin
                port_hit = port_hit | grant_nxt[f][p];
            end
        end

        // Per-port saturating grant counter
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                grant_cnt[p*CNT_W +: CNT_W] <= '0;
            end else if (cnt_clr) begin
                grant_cnt[p*CNT_W +: CNT_W] <= '0;
            end else if (port_hit && (grant_cnt[p*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                grant_cnt[p*CNT_W +: CNT_W] <= grant_cnt[p*CNT_W +: CNT_W] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bless_port_alloc.sv
// Directed self-checking bench for bless_port_alloc (built with CNT_W=4 so
// saturation is reachable quickly).
`timescale 1ns/1ps
module tb_bless_port_alloc;

    localparam int NP = 4;
    localparam int NF = 4;
    localparam int CW = 4;

    logic              clk;
    logic              rst_n;
    logic [NF-1:0]     in_valid;
    logic [NF*NP-1:0]  in_prod;
    logic [NP-1:0]     port_en;
    logic              cnt_clr;
    logic [NF-1:0]     out_valid;
    logic [NF*NP-1:0]  out_grant;
    logic [NF-1:0]     out_defl;
    logic              out_ovf;
    logic [CW-1:0]     defl_cnt;
`ifdef BLESS_ALLOC_STATS_EN
    logic [NP*CW-1:0]  grant_cnt;
`endif

    int n_chk;
    int n_fail;

    bless_port_alloc #(.NUM_PORT(NP), .NUM_FLIT(NF), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_prod   (in_prod),
        .port_en   (port_en),
        .cnt_clr   (cnt_clr),
        .out_valid (out_valid),
        .out_grant (out_grant),
        .out_defl  (out_defl),
        .out_ovf   (out_ovf),
        .defl_cnt  (defl_cnt)
`ifdef BLESS_ALLOC_STATS_EN
       ,.grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, then sample 1ns after the next rising edge
    task automatic step(input logic [NF-1:0] v, input logic [NF*NP-1:0] p,
                        input logic [NP-1:0] en, input logic clr);
        in_valid = v;
        in_prod  = p;
        port_en  = en;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cnt_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = NF'($urandom);
            in_prod  = (NF*NP)'($urandom);
            port_en  = NP'($urandom);
            @(posedge clk);
            #1;
            n_chk++;
            if ({out_valid, out_grant, out_defl, out_ovf, defl_cnt} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold: got valid=%b grant=%b defl=%b ovf=%b cnt=%0d, want all 0",
                         out_valid, out_grant, out_defl, out_ovf, defl_cnt);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        step('0, '0, 4'b1111, 1'b0);
    endtask

    task automatic test_contention();
        step(4'b1111, {4'b0001, 4'b0001, 4'b0100, 4'b0110}, 4'b1111, 1'b0);
        n_chk++;
        if (out_grant !== {4'b0010, 4'b0001, 4'b1000, 4'b0100}) begin
            n_fail++;
            $display("FAIL contention_grant: got %b want 0010_0001_1000_0100", out_grant);
        end
        n_chk++;
        if (out_defl !== 4'b1010 || out_ovf !== 1'b0 || out_valid !== 4'b1111) begin
            n_fail++;
            $display("FAIL contention_flags: got defl=%b ovf=%b valid=%b want 1010 0 1111",
                     out_defl, out_ovf, out_valid);
        end
        n_chk++;
        if (defl_cnt !== 4'd2) begin
            n_fail++;
            $display("FAIL contention_cnt: got %0d want 2", defl_cnt);
        end
    endtask

    task automatic test_overflow();
        step(4'b0111, {4'b0000, 4'b0001, 4'b0001, 4'b0001}, 4'b0011, 1'b0);
        n_chk++;
        if (out_grant !== {4'b0000, 4'b0000, 4'b0010, 4'b0001}) begin
            n_fail++;
            $display("FAIL overflow_grant: got %b want 0000_0000_0010_0001", out_grant);
        end
        n_chk++;
        if (out_defl !== 4'b0010 || out_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flags: got defl=%b ovf=%b want 0010 1", out_defl, out_ovf);
        end
        n_chk++;
        if (defl_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL overflow_cnt: got %0d want 3", defl_cnt);
        end
    endtask

    task automatic test_invalid_gaps();
        step(4'b1010, {4'b1000, 4'b1111, 4'b1000, 4'b1111}, 4'b1111, 1'b0);
        n_chk++;
        if (out_grant !== {4'b0100, 4'b0000, 4'b1000, 4'b0000}) begin
            n_fail++;
            $display("FAIL gaps_grant: got %b want 0100_0000_1000_0000", out_grant);
        end
        n_chk++;
        if (out_defl !== 4'b1000 || out_ovf !== 1'b0 || out_valid !== 4'b1010) begin
            n_fail++;
            $display("FAIL gaps_flags: got defl=%b ovf=%b valid=%b want 1000 0 1010",
                     out_defl, out_ovf, out_valid);
        end
        n_chk++;
        if (defl_cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL gaps_cnt: got %0d want 4", defl_cnt);
        end
    endtask

    task automatic test_counter();
        int exp;
        step('0, '0, 4'b1111, 1'b1);
        n_chk++;
        if (defl_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL cnt_clear_idle: got %0d want 0", defl_cnt);
        end
        exp = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, {4'b0001, 4'b0001, 4'b0100, 4'b0110}, 4'b1111, 1'b0);
            exp = (exp + 2 > 15) ? 15 : exp + 2;
            n_chk++;
            if (defl_cnt !== CW'(exp)) begin
                n_fail++;
                $display("FAIL cnt_sat[%0d]: got %0d want %0d", i, defl_cnt, exp);
            end
        end
        step(4'b1111, {4'b0001, 4'b0001, 4'b0100, 4'b0110}, 4'b1111, 1'b1);
        n_chk++;
        if (defl_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL cnt_clr_wins: got %0d want 0", defl_cnt);
        end
    endtask

    task automatic test_stats();
`ifdef BLESS_ALLOC_STATS_EN
        step('0, '0, 4'b1111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, {4'b0001, 4'b0001, 4'b0100, 4'b0110}, 4'b1111, 1'b0);
        end
        n_chk++;
        if (grant_cnt !== {4'd3, 4'd3, 4'd3, 4'd3}) begin
            n_fail++;
            $display("FAIL stats_grant_cnt: got %h want 3333", grant_cnt);
        end
`endif
    endtask

    task automatic test_async_reset();
        step(4'b1111, {4'b0001, 4'b0001, 4'b0100, 4'b0110}, 4'b1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({out_valid, out_grant, out_defl, out_ovf, defl_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b grant=%b defl=%b ovf=%b cnt=%0d, want all 0",
                     out_valid, out_grant, out_defl, out_ovf, defl_cnt);
        end
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        in_valid = '0;
        in_prod = '0;
        port_en = '0;
        cnt_clr = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_contention();
        test_overflow();
        test_invalid_gaps();
        test_counter();
        test_stats();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
